// File: rtl/md_ori_buf.sv
`default_nettype none
// ============================================================================
// Module      : md_ori_buf
// Description : Ping-pong 64x64 luma original-pixel buffer. The LCU loader
//               fills the write bank in 256-bit beats while mode-decision
//               fetchers read 4x4..32x32 block rows from the read bank with
//               one cycle of registered latency.
// Revision    : 1.0 - initial release
// ============================================================================
module md_ori_buf #(
    parameter int PIX_W = 8,
    parameter int LCU_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_start_i,
    output logic         ld_ready_o,
    input  logic         ld_valid_i,
    input  logic [255:0] ld_data_i,
    output logic         ld_done_o,
    output logic         rd_full_o,
    input  logic         rd_release_i,
    input  logic         md_ren_i,
    input  logic         md_sel_i,
    input  logic [1:0]   md_size_i,
    input  logic [3:0]   md_4x4_x_i,
    input  logic [3:0]   md_4x4_y_i,
    input  logic [4:0]   md_idx_i,
    output logic         md_valid_o,
    output logic [255:0] md_data_o
);

    localparam int C_ROW_BITS = PIX_W * LCU_W;     // one full LCU row
    localparam int C_DEPTH    = 2 * LCU_W;         // two banks of rows
    localparam logic [6:0] C_LAST_BEAT = 7'd127;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_LOAD = 2'd1,
        W_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [6:0]            r_cnt;
    logic                  r_p;
    logic                  r_full;
    logic                  r_done;
    logic                  r_md_valid;
    logic [255:0]          r_md_data;
    logic [C_ROW_BITS-1:0] r_mem [0:C_DEPTH-1];

    logic                  w_wr_en;
    logic                  w_last_beat;
    logic                  w_swap;
    logic [6:0]            w_wr_addr;
    logic [5:0]            w_x0;
    logic [5:0]            w_y0;
    logic [C_ROW_BITS-1:0] w_rows [4];
    logic [255:0]          w_rd_data;

    assign w_wr_en     = (r_state == W_LOAD) && ld_valid_i && !rst;
    assign w_last_beat = (r_state == W_LOAD) && ld_valid_i && (r_cnt == C_LAST_BEAT);
    assign w_swap      = (r_state == W_WAIT) && (!r_full || rd_release_i);
    // Write bank is p; each row takes two beats (left half, right half)
    assign w_wr_addr   = {r_p, r_cnt[6:1]};
    assign w_x0        = {md_4x4_x_i, 2'b00};
    assign w_y0        = {md_4x4_y_i, 2'b00};

    assign ld_ready_o  = (r_state == W_IDLE);
    assign ld_done_o   = r_done;
    assign rd_full_o   = r_full;
    assign md_valid_o  = r_md_valid;
    assign md_data_o   = r_md_data;

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= W_IDLE;
        else     r_state <= w_next_state;
    end

    // Write FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            W_IDLE:  if (ld_start_i)  w_next_state = W_LOAD;
            W_LOAD:  if (w_last_beat) w_next_state = W_WAIT;
            W_WAIT:  if (w_swap)      w_next_state = W_IDLE;
            default: w_next_state = W_IDLE;
        endcase
    end

    // Beat counter, bank pointer, full flag and load-done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_p    <= 1'b0;
            r_full <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last_beat;
            if (r_state == W_IDLE && ld_start_i) r_cnt <= '0;
            else if (w_wr_en)                    r_cnt <= r_cnt + 7'd1;
            if (w_swap) begin
                r_p    <= ~r_p;
                r_full <= 1'b1;
            end else if (rd_release_i && r_full) begin
                r_full <= 1'b0;
            end
        end
    end

    // Pixel storage: beat with even index fills the left half of a row
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            if (r_cnt[0]) r_mem[w_wr_addr][C_ROW_BITS/2-1:0]          <= ld_data_i;
            else          r_mem[w_wr_addr][C_ROW_BITS-1:C_ROW_BITS/2] <= ld_data_i;
        end
    end

    // Fetch the (up to) four consecutive rows a block read can touch
    for (genvar K = 0; K < 4; K++) begin : g_row
        logic [5:0] w_row_addr;
        assign w_row_addr = w_y0 + {1'b0, md_idx_i} + 6'(K);
        assign w_rows[K]  = r_mem[{~r_p, w_row_addr}];
    end

    // Each output pixel slot picks its row and column for the requested size
    for (genvar J = 0; J < 32; J++) begin : g_slot
        localparam logic [1:0] K4  = 2'((J / 4) % 4);
        localparam logic [4:0] C4  = 5'(J % 4);
        localparam logic       Z4  = (J >= 16);
        localparam logic [1:0] K8  = 2'(J / 8);
        localparam logic [4:0] C8  = 5'(J % 8);
        localparam logic [1:0] K16 = 2'(J / 16);
        localparam logic [4:0] C16 = 5'(J % 16);
        localparam logic [4:0] C32 = 5'(J);

        logic [1:0] w_k;
        logic [4:0] w_c;
        logic       w_zero;
        logic [5:0] w_col;

        // Slot-to-(row, column) mapping, row-major packing
        always_comb begin
            w_k    = '0;
            w_c    = '0;
            w_zero = 1'b0;
            case (md_size_i)
                2'b00:   begin w_k = K4;  w_c = C4;  w_zero = Z4; end
                2'b01:   begin w_k = K8;  w_c = C8;  end
                2'b10:   begin w_k = K16; w_c = C16; end
                default: begin w_k = 2'd0; w_c = C32; end
            endcase
        end

        // Column wraps modulo 64; column c sits at bits [511-8c -: 8]
        assign w_col = w_x0 + {1'b0, w_c};
        assign w_rd_data[255-8*J -: 8] = w_zero ? 8'h00 : w_rows[w_k][{~w_col, 3'b111} -: 8];
    end

    // Registered read response
    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_valid <= 1'b0;
            r_md_data  <= '0;
        end else begin
            r_md_valid <= md_ren_i;
            r_md_data  <= (md_ren_i && !md_sel_i && r_full) ? w_rd_data : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_ori_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_ori_buf
// Description : Directed self-checking bench for md_ori_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_ori_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         ld_start_i;
    logic         ld_ready_o;
    logic         ld_valid_i;
    logic [255:0] ld_data_i;
    logic         ld_done_o;
    logic         rd_full_o;
    logic         rd_release_i;
    logic         md_ren_i;
    logic         md_sel_i;
    logic [1:0]   md_size_i;
    logic [3:0]   md_4x4_x_i;
    logic [3:0]   md_4x4_y_i;
    logic [4:0]   md_idx_i;
    logic         md_valid_o;
    logic [255:0] md_data_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    md_ori_buf #(.PIX_W(8), .LCU_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_start_i   (ld_start_i),
        .ld_ready_o   (ld_ready_o),
        .ld_valid_i   (ld_valid_i),
        .ld_data_i    (ld_data_i),
        .ld_done_o    (ld_done_o),
        .rd_full_o    (rd_full_o),
        .rd_release_i (rd_release_i),
        .md_ren_i     (md_ren_i),
        .md_sel_i     (md_sel_i),
        .md_size_i    (md_size_i),
        .md_4x4_x_i   (md_4x4_x_i),
        .md_4x4_y_i   (md_4x4_y_i),
        .md_idx_i     (md_idx_i),
        .md_valid_o   (md_valid_o),
        .md_data_o    (md_data_o)
    );

    // Reference picture: p(x,y) = (64y + x + off) mod 256
    function automatic logic [255:0] mk_beat(input int off, input int b);
        logic [255:0] v;
        int row, col;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            row = b / 2;
            col = (b % 2) * 32 + i;
            v[255-8*i -: 8] = 8'((64 * row + col + off) % 256);
        end
        return v;
    endfunction

    function automatic logic [255:0] exp_blk(input int off, input int size, input int x4,
                                             input int y4, input int idx);
        logic [255:0] v;
        int w, r, slot, row, col;
        v = '0;
        w = 4 << size;
        r = (w == 4) ? 4 : 32 / w;
        for (int k = 0; k < r; k++) begin
            for (int c = 0; c < w; c++) begin
                slot = k * w + c;
                row  = (4 * y4 + idx + k) % 64;
                col  = (4 * x4 + c) % 64;
                v[255-8*slot -: 8] = 8'((64 * row + col + off) % 256);
            end
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input logic [1:0] size, input logic [3:0] x4, input logic [3:0] y4,
                            input logic [4:0] idx, input logic sel);
        md_ren_i   = 1'b1;
        md_sel_i   = sel;
        md_size_i  = size;
        md_4x4_x_i = x4;
        md_4x4_y_i = y4;
        md_idx_i   = idx;
    endtask

    task automatic issue_read(input logic [1:0] size, input logic [3:0] x4, input logic [3:0] y4,
                              input logic [4:0] idx, input logic sel);
        set_read(size, x4, y4, idx, sel);
        tick();
        md_ren_i = 1'b0;
    endtask

    task automatic drive_beats(input int off, input int b0, input int b1, output int dones);
        dones = 0;
        for (int b = b0; b < b1; b++) begin
            ld_valid_i = 1'b1;
            ld_data_i  = mk_beat(off, b);
            tick();
            if (ld_done_o) dones++;
        end
        ld_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        n_total++; if (ld_ready_o !== 1'b1) $display("FAIL reset_ready act=%b req=1", ld_ready_o); else n_pass++;
        n_total++; if (rd_full_o !== 1'b0) $display("FAIL reset_full act=%b req=0", rd_full_o); else n_pass++;
        n_total++; if (md_valid_o !== 1'b0) $display("FAIL reset_valid act=%b req=0", md_valid_o); else n_pass++;
        n_total++; if (md_data_o !== '0) $display("FAIL reset_data act=%h req=0", md_data_o); else n_pass++;
        n_total++; if (ld_done_o !== 1'b0) $display("FAIL reset_done act=%b req=0", ld_done_o); else n_pass++;
        rst = 1'b0;
        // Read with no full bank returns zero data but a valid strobe
        issue_read(2'b01, 4'd0, 4'd0, 5'd0, 1'b0);
        n_total++; if (md_valid_o !== 1'b1 || md_data_o !== '0)
            $display("FAIL empty_read act=%b/%h req=1/0", md_valid_o, md_data_o); else n_pass++;
    endtask

    task automatic test_load;
        int d;
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
        n_total++; if (ld_ready_o !== 1'b0) $display("FAIL load_busy act=%b req=0", ld_ready_o); else n_pass++;
        drive_beats(0, 0, 128, d);
        n_total++; if (d !== 1 || ld_done_o !== 1'b1)
            $display("FAIL load_done act=%0d/%b req=1/1", d, ld_done_o); else n_pass++;
        n_total++; if (rd_full_o !== 1'b0) $display("FAIL load_prefull act=%b req=0", rd_full_o); else n_pass++;
        tick();
        n_total++; if (rd_full_o !== 1'b1 || ld_ready_o !== 1'b1 || ld_done_o !== 1'b0)
            $display("FAIL load_swap act=%b%b%b req=110", rd_full_o, ld_ready_o, ld_done_o); else n_pass++;
    endtask

    task automatic test_read_8x8;
        issue_read(2'b01, 4'd2, 4'd4, 5'd4, 1'b0);
        n_total++; if (md_valid_o !== 1'b1) $display("FAIL r8_valid act=%b req=1", md_valid_o); else n_pass++;
        n_total++; if (md_data_o[255:248] !== 8'h08) $display("FAIL r8_b0 act=%h req=08", md_data_o[255:248]); else n_pass++;
        n_total++; if (md_data_o[191:184] !== 8'h48) $display("FAIL r8_b8 act=%h req=48", md_data_o[191:184]); else n_pass++;
        n_total++; if (md_data_o !== exp_blk(0, 1, 2, 4, 4))
            $display("FAIL r8_full act=%h req=%h", md_data_o, exp_blk(0, 1, 2, 4, 4)); else n_pass++;
        tick();
        n_total++; if (md_valid_o !== 1'b0 || md_data_o !== '0)
            $display("FAIL r8_idle act=%b/%h req=0/0", md_valid_o, md_data_o); else n_pass++;
    endtask

    task automatic test_read_wrap;
        issue_read(2'b11, 4'd12, 4'd0, 5'd0, 1'b0);
        n_total++; if (md_data_o[255:248] !== 8'h30 || md_data_o[127:120] !== 8'h00)
            $display("FAIL r32_wrap act=%h,%h req=30,00", md_data_o[255:248], md_data_o[127:120]); else n_pass++;
        n_total++; if (md_data_o !== exp_blk(0, 3, 12, 0, 0))
            $display("FAIL r32_full act=%h req=%h", md_data_o, exp_blk(0, 3, 12, 0, 0)); else n_pass++;
        // 4x4 wrapping in both directions; lower half must be zero
        issue_read(2'b00, 4'd15, 4'd15, 5'd3, 1'b0);
        n_total++; if (md_data_o[127:0] !== '0) $display("FAIL r4_low act=%h req=0", md_data_o[127:0]); else n_pass++;
        n_total++; if (md_data_o !== exp_blk(0, 0, 15, 15, 3))
            $display("FAIL r4_full act=%h req=%h", md_data_o, exp_blk(0, 0, 15, 15, 3)); else n_pass++;
        issue_read(2'b10, 4'd7, 4'd2, 5'd9, 1'b0);
        n_total++; if (md_data_o !== exp_blk(0, 2, 7, 2, 9))
            $display("FAIL r16_full act=%h req=%h", md_data_o, exp_blk(0, 2, 7, 2, 9)); else n_pass++;
        issue_read(2'b01, 4'd1, 4'd1, 5'd0, 1'b1);
        n_total++; if (md_valid_o !== 1'b1 || md_data_o !== '0)
            $display("FAIL chroma act=%b/%h req=1/0", md_valid_o, md_data_o); else n_pass++;
    endtask

    task automatic test_second_load;
        int d;
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
        drive_beats(1, 0, 64, d);
        // Read concurrent with a load beat sees the old bank
        ld_valid_i = 1'b1;
        ld_data_i  = mk_beat(1, 64);
        set_read(2'b10, 4'd3, 4'd5, 5'd1, 1'b0);
        tick();
        md_ren_i = 1'b0;
        n_total++; if (md_data_o !== exp_blk(0, 2, 3, 5, 1))
            $display("FAIL ovl_read act=%h req=%h", md_data_o, exp_blk(0, 2, 3, 5, 1)); else n_pass++;
        drive_beats(1, 65, 128, d);
        n_total++; if (d !== 1) $display("FAIL load2_done act=%0d req=1", d); else n_pass++;
        tick();
        tick();
        tick();
        n_total++; if (rd_full_o !== 1'b1 || ld_ready_o !== 1'b0)
            $display("FAIL wait_hold act=%b%b req=10", rd_full_o, ld_ready_o); else n_pass++;
        // Release and read in the swap cycle: old bank returned, swap happens
        rd_release_i = 1'b1;
        set_read(2'b01, 4'd2, 4'd4, 5'd4, 1'b0);
        tick();
        rd_release_i = 1'b0;
        md_ren_i     = 1'b0;
        n_total++; if (md_data_o !== exp_blk(0, 1, 2, 4, 4))
            $display("FAIL swap_read act=%h req=%h", md_data_o, exp_blk(0, 1, 2, 4, 4)); else n_pass++;
        n_total++; if (rd_full_o !== 1'b1 || ld_ready_o !== 1'b1)
            $display("FAIL swap_state act=%b%b req=11", rd_full_o, ld_ready_o); else n_pass++;
        issue_read(2'b01, 4'd2, 4'd4, 5'd4, 1'b0);
        n_total++; if (md_data_o[255:248] !== 8'h09 || md_data_o !== exp_blk(1, 1, 2, 4, 4))
            $display("FAIL new_bank act=%h req=%h", md_data_o, exp_blk(1, 1, 2, 4, 4)); else n_pass++;
    endtask

    task automatic test_release;
        rd_release_i = 1'b1;
        tick();
        rd_release_i = 1'b0;
        n_total++; if (rd_full_o !== 1'b0) $display("FAIL release act=%b req=0", rd_full_o); else n_pass++;
        issue_read(2'b11, 4'd0, 4'd0, 5'd0, 1'b0);
        n_total++; if (md_valid_o !== 1'b1 || md_data_o !== '0)
            $display("FAIL rel_read act=%b/%h req=1/0", md_valid_o, md_data_o); else n_pass++;
    endtask

    task automatic test_reset_midload;
        int d;
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
        drive_beats(7, 0, 41, d);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (ld_ready_o !== 1'b1 || rd_full_o !== 1'b0)
            $display("FAIL mid_rst act=%b%b req=10", ld_ready_o, rd_full_o); else n_pass++;
        drive_beats(9, 0, 10, d);
        n_total++; if (ld_ready_o !== 1'b1 || d !== 0)
            $display("FAIL stray_valid act=%b/%0d req=1/0", ld_ready_o, d); else n_pass++;
        ld_start_i = 1'b1;
        tick();
        ld_start_i = 1'b0;
        drive_beats(3, 0, 128, d);
        tick();
        n_total++; if (rd_full_o !== 1'b1) $display("FAIL reload_full act=%b req=1", rd_full_o); else n_pass++;
        issue_read(2'b11, 4'd5, 4'd9, 5'd17, 1'b0);
        n_total++; if (md_data_o !== exp_blk(3, 3, 5, 9, 17))
            $display("FAIL reload_data act=%h req=%h", md_data_o, exp_blk(3, 3, 5, 9, 17)); else n_pass++;
    endtask

    initial begin
        rst          = 1'b1;
        ld_start_i   = 1'b0;
        ld_valid_i   = 1'b0;
        ld_data_i    = '0;
        rd_release_i = 1'b0;
        md_ren_i     = 1'b0;
        md_sel_i     = 1'b0;
        md_size_i    = 2'b00;
        md_4x4_x_i   = '0;
        md_4x4_y_i   = '0;
        md_idx_i     = '0;
        test_reset();
        test_load();
        test_read_8x8();
        test_read_wrap();
        test_second_load();
        test_release();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
